// File: rtl/time_memory_scanner_pkg.sv
// Shared constants for the time/alarm/chronometer read-side scanner.
// Field map, default field count, FSM encoding and a BCD nibble helper.
package time_memory_scanner_pkg;

  localparam int NUM_FIELDS_DEF = 11;

  localparam logic [3:0] FLD_SEG       = 4'd0;
  localparam logic [3:0] FLD_MIN       = 4'd1;
  localparam logic [3:0] FLD_HOR       = 4'd2;
  localparam logic [3:0] FLD_DIA       = 4'd3;
  localparam logic [3:0] FLD_ALM_SEG   = 4'd4;
  localparam logic [3:0] FLD_ALM_MIN   = 4'd5;
  localparam logic [3:0] FLD_ALM_HOR   = 4'd6;
  localparam logic [3:0] FLD_ALM_DIA   = 4'd7;
  localparam logic [3:0] FLD_CRONO_SEG = 4'd8;
  localparam logic [3:0] FLD_CRONO_MIN = 4'd9;
  localparam logic [3:0] FLD_CRONO_HOR = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  function automatic logic nib_ok(input logic [3:0] n);
    return (n <= 4'd9);
  endfunction

endpackage

// File: rtl/time_memory_scanner_bcd_byte_check.sv
// Combinational BCD validator: flags bytes with a nibble above 9.
// Only compiled when BCD_CHECK_EN is defined (the sole user).
`ifdef BCD_CHECK_EN
module bcd_byte_check
  import time_memory_scanner_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_valid,
  output logic [7:0] o_byte
);

  assign o_valid = nib_ok(i_byte[7:4]) && nib_ok(i_byte[3:0]);
  assign o_byte  = o_valid ? i_byte : 8'h00;

endmodule
`endif

// File: rtl/time_memory_scanner.sv
// Frame scanner: reads all time fields into a shadow bank, commits atomically.
// Optional BCD_CHECK_EN sanitizes non-BCD bytes and raises sticky bcd_err.
module time_memory_scanner
  import time_memory_scanner_pkg::*;
#(
  parameter int NUM_FIELDS = NUM_FIELDS_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       hold,
  output logic       rd_en,
  output logic [3:0] rd_addr,
  input  logic [7:0] rd_data,
  input  logic [3:0] disp_sel,
  output logic [7:0] disp_data,
  output logic       frame_done,
  output logic       busy,
  output logic       bcd_err
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_FIELDS - 1);
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);
  localparam logic [4:0] NFLD     = 5'(NUM_FIELDS);

  state_t     r_state;
  logic [3:0] r_idx;
  logic [1:0] r_lat;
  logic       r_pend;
  logic [7:0] r_work [NUM_FIELDS];
  logic [7:0] r_disp [NUM_FIELDS];

  logic       w_start;
  logic       w_cap;
  logic [7:0] w_byte;

  assign w_start = (r_state == ST_IDLE) && (refresh_tick || r_pend);
  assign w_cap   = (r_state == ST_WAIT) && (r_lat == LAT_LAST);

  assign rd_en      = (r_state == ST_ISSUE) && !hold;
  assign rd_addr    = r_idx;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_COMMIT);
  assign disp_data  = ({1'b0, disp_sel} < NFLD) ? r_disp[disp_sel] : 8'h00;

`ifdef BCD_CHECK_EN
  logic       w_ok;
  logic [7:0] w_clean;
  logic       r_bcd_err;

  bcd_byte_check u_bcd (
    .i_byte  (rd_data),
    .o_valid (w_ok),
    .o_byte  (w_clean)
  );

  assign w_byte  = w_clean;
  assign bcd_err = r_bcd_err;

  // sticky error: set on a bad capture, cleared when a frame starts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcd_err <= 1'b0;
    end else if (w_start) begin
      r_bcd_err <= 1'b0;
    end else if (w_cap && !w_ok) begin
      r_bcd_err <= 1'b1;
    end
  end
`else
  assign w_byte  = rd_data;
  assign bcd_err = 1'b0;
`endif

  // scan sequencer, pending-tick flag, working and display banks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_lat   <= '0;
      r_pend  <= 1'b0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        r_work[i] <= '0;
        r_disp[i] <= '0;
      end
    end else begin
      if (busy && refresh_tick) r_pend <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_ISSUE;
            r_idx   <= '0;
            r_pend  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (!hold) begin
            r_state <= ST_WAIT;
            r_lat   <= '0;
          end
        end
        ST_WAIT: begin
          if (w_cap) begin
            r_work[r_idx] <= w_byte;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_COMMIT;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= ST_ISSUE;
            end
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < NUM_FIELDS; i++) begin
            r_disp[i] <= r_work[i];
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_memory_scanner.sv
// Directed bench for time_memory_scanner with a 1-cycle memory model.
// Cycle 0 is the cycle in which the first refresh_tick is driven.
module tb_time_memory_scanner;

  logic       clk;
  logic       reset;
  logic       refresh_tick;
  logic       hold;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] disp_sel;
  logic [7:0] disp_data;
  logic       frame_done;
  logic       busy;
  logic       bcd_err;

  time_memory_scanner dut (
    .clk          (clk),
    .reset        (reset),
    .refresh_tick (refresh_tick),
    .hold         (hold),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .disp_sel     (disp_sel),
    .disp_data    (disp_data),
    .frame_done   (frame_done),
    .busy         (busy),
    .bcd_err      (bcd_err)
  );

`ifdef BCD_CHECK_EN
  localparam logic [7:0] EXP_F2  = 8'h00;
  localparam logic       EXP_ERR = 1'b1;
`else
  localparam logic [7:0] EXP_F2  = 8'h3A;
  localparam logic       EXP_ERR = 1'b0;
`endif

  logic [7:0] mem [16];
  int n_chk;
  int n_err;
  int cyc;
  int tick_q [$];
  int rd_cyc [$];
  int rd_adr [$];
  int done_cyc [$];
  int hold_lo, hold_hi, rst_lo, rst_hi;
  int wr_cyc, wr_adr;
  logic [7:0] wr_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic disp_chk(input string tag,
                          input logic [3:0] sel,
                          input logic [7:0] exp);
    disp_sel = sel;
    #1;
    chk(tag, {24'd0, disp_data}, {24'd0, exp});
  endtask

  task automatic new_scn();
    cyc = -1;
    tick_q.delete();
    rd_cyc.delete();
    rd_adr.delete();
    done_cyc.delete();
    hold_lo = -100;
    hold_hi = -100;
    rst_lo  = -100;
    rst_hi  = -100;
    wr_cyc  = -100;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    refresh_tick = 1'b0;
    foreach (tick_q[i]) if (tick_q[i] == cyc) refresh_tick = 1'b1;
    hold  = (cyc >= hold_lo) && (cyc < hold_hi);
    reset = !((cyc >= rst_lo) && (cyc < rst_hi));
    if (cyc == wr_cyc) mem[wr_adr] = wr_val;
    #1;
    if (rd_en) begin
      rd_cyc.push_back(cyc);
      rd_adr.push_back(int'(rd_addr));
    end
    if (frame_done) done_cyc.push_back(cyc);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    refresh_tick = 1'b0;
    hold = 1'b0;
    disp_sel = 4'd0;
    rd_data = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
    for (int i = 0; i < 10; i++) mem[i] = 8'(i);
    mem[10] = 8'h10;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_bcd_err", bcd_err, 0);
    disp_chk("rst_disp0", 4'd0, 8'h00);
    disp_chk("rst_disp10", 4'd10, 8'h00);
    reset = 1'b1;

    // basic frame
    new_scn();
    tick_q.push_back(0);
    run_to(12);
    chk("t1_busy_mid", busy, 1);
    run_to(30);
    chk("t1_rd_cnt", rd_cyc.size(), 11);
    for (int i = 0; i < 11; i++) begin
      if (i < rd_cyc.size()) begin
        chk($sformatf("t1_rd_cyc%0d", i), rd_cyc[i], 1 + 2 * i);
        chk($sformatf("t1_rd_adr%0d", i), rd_adr[i], i);
      end
    end
    chk("t1_done_cnt", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("t1_done_cyc", done_cyc[0], 23);
    chk("t1_busy_end", busy, 0);
    chk("t1_addr_hold", rd_addr, 10);
    disp_chk("t1_disp10", 4'd10, 8'h10);
    disp_chk("t1_disp5", 4'd5, 8'h05);
    disp_chk("t1_disp11", 4'd11, 8'h00);
    disp_chk("t1_disp15", 4'd15, 8'h00);

    // hold stall on field 3
    mem[3] = 8'h31;
    new_scn();
    tick_q.push_back(0);
    hold_lo = 7;
    hold_hi = 12;
    run_to(35);
    chk("t2_rd_cnt", rd_cyc.size(), 11);
    if (rd_cyc.size() > 3) begin
      chk("t2_rd2_cyc", rd_cyc[2], 5);
      chk("t2_rd3_cyc", rd_cyc[3], 12);
      chk("t2_rd3_adr", rd_adr[3], 3);
    end
    chk("t2_done_cnt", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("t2_done_cyc", done_cyc[0], 28);
    disp_chk("t2_disp3", 4'd3, 8'h31);

    // three ticks mid-frame -> one extra frame
    new_scn();
    tick_q.push_back(0);
    tick_q.push_back(5);
    tick_q.push_back(9);
    tick_q.push_back(15);
    run_to(90);
    chk("t3_done_cnt", done_cyc.size(), 2);
    if (done_cyc.size() > 1) begin
      chk("t3_done0", done_cyc[0], 23);
      chk("t3_done1", done_cyc[1], 47);
    end
    chk("t3_rd_cnt", rd_cyc.size(), 22);
    if (rd_cyc.size() > 11) chk("t3_f2_start", rd_cyc[11], 25);

    // torn-frame protection
    mem[0] = 8'h59;
    new_scn();
    tick_q.push_back(0);
    tick_q.push_back(30);
    wr_cyc = 5;
    wr_adr = 0;
    wr_val = 8'h00;
    run_to(22);
    disp_chk("t4_disp_pre", 4'd0, 8'h00);
    run_to(24);
    disp_chk("t4_disp_f1", 4'd0, 8'h59);
    run_to(53);
    disp_chk("t4_disp_commit", 4'd0, 8'h59);
    run_to(54);
    disp_chk("t4_disp_f2", 4'd0, 8'h00);

    // reset mid-frame
    new_scn();
    tick_q.push_back(0);
    tick_q.push_back(45);
    rst_lo = 10;
    rst_hi = 12;
    run_to(10);
    chk("t5_busy", busy, 0);
    chk("t5_rd_en", rd_en, 0);
    chk("t5_rd_addr", rd_addr, 0);
    chk("t5_done", frame_done, 0);
    disp_chk("t5_disp10", 4'd10, 8'h00);
    run_to(44);
    chk("t5_no_done", done_cyc.size(), 0);
    chk("t5_idle", busy, 0);
    run_to(70);
    chk("t5_done_cnt", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("t5_done_cyc", done_cyc[0], 68);
    disp_chk("t5_disp10b", 4'd10, 8'h10);

    // non-BCD byte in field 2
    mem[2] = 8'h3A;
    new_scn();
    tick_q.push_back(0);
    tick_q.push_back(30);
    run_to(25);
    disp_chk("t6_disp2", 4'd2, EXP_F2);
    chk("t6_err", bcd_err, EXP_ERR);
    run_to(29);
    chk("t6_err_sticky", bcd_err, EXP_ERR);
    run_to(31);
    chk("t6_err_clr", bcd_err, 0);
    run_to(55);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/time_memory_scanner.md
# time_memory_scanner

Read-side sequencer for the time/alarm/chronometer register memory. On each refresh tick it walks the 11 time fields in order, issuing one read per field and capturing the returned byte into a working shadow bank. At end of frame it commits the working bank to a display bank in one cycle, so the display/formatting logic never sees a torn frame. It sits between the register memory's read port and the display driver, and yields the memory port to writers through a hold input.

## Interface
- NUM_FIELDS, 11, fields scanned per frame; indices 0..NUM_FIELDS-1 map to addresses 0..NUM_FIELDS-1
- RD_LATENCY, 1, cycles from rd_en sampled high to rd_data valid (1..3)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- refresh_tick  in  1  one-cycle pulse requesting a new frame
- hold  in  1  writer owns memory port; blocks new read issue
- rd_en  out  1  read strobe to memory
- rd_addr  out  4  field address being read
- rd_data  in  8  memory read data, BCD
- disp_sel  in  4  display-side field select
- disp_data  out  8  committed byte for disp_sel (combinational from display bank); 0 for disp_sel >= NUM_FIELDS
- frame_done  out  1  one-cycle pulse, display bank updated
- busy  out  1  high in any state other than IDLE
- bcd_err  out  1  sticky, see Configuration

## Operation
- Field order: 0 seconds, 1 minutes, 2 hours, 3 days, 4–7 alarm s/m/h/d, 8–10 chronometer s/m/h.
- States: IDLE, ISSUE, WAIT, COMMIT.
- IDLE: refresh_tick or pending flag set -> ISSUE with field index = 0; pending cleared.
- ISSUE: if hold=0, rd_en=1 and rd_addr=index for exactly one cycle -> WAIT. If hold=1, rd_en=0 and remain in ISSUE.
- WAIT: counts RD_LATENCY cycles and captures rd_data into working[index] on the last WAIT cycle. hold is ignored here because the read is already in flight. Then, if index = NUM_FIELDS-1 -> COMMIT, else index+1 -> ISSUE.
- COMMIT: display bank <= working bank (all fields), frame_done=1 for this cycle -> IDLE.
- refresh_tick while busy: sets the one-deep pending flag. Additional ticks are dropped. A tick arriving in COMMIT starts the next frame on the cycle after COMMIT.
- rd_addr holds its last value when rd_en=0. Only rd_en is qualifying.

## Timing
- Reset (asynchronous assert): state IDLE, index 0, pending 0, rd_en 0, rd_addr 0, frame_done 0, busy 0, bcd_err 0, both banks all 0, so disp_data = 0.
- Reset mid-frame: the frame is abandoned and the display bank is cleared. No frame_done.
- Per field: 1 + RD_LATENCY cycles plus hold stall cycles.
- Frame with no hold: tick at cycle 0 -> ISSUE at cycle 1 -> COMMIT at cycle NUM_FIELDS*(1+RD_LATENCY)+1. With defaults, frame_done is at cycle 23.
- disp_data changes only on the clock edge that ends COMMIT.

## Configuration
- BCD_CHECK_EN defined:
  - On capture, any nibble > 9 stores 8'h00 into working[index] and sets bcd_err.
  - bcd_err clears on the next refresh_tick that starts a frame.
- Not defined:
  - Bytes are stored unmodified.
  - bcd_err is tied to 0 and the checker logic is absent.

## Structure
- Shared package holds:
  - field index constants (FLD_SEG..FLD_CRONO_HOR)
  - NUM_FIELDS default
  - state encoding constants
- Sub-module bcd_byte_check:
  - combinational 8-bit input -> valid flag and sanitized byte
  - instantiated only under BCD_CHECK_EN

## Test plan
- Preload memory fields 0..10 with 8'h00..8'h10 BCD (8'h00, 8'h01, … 8'h09, 8'h10); pulse refresh_tick -> 11 rd_en pulses at addresses 0..10, 2 cycles apart; frame_done at cycle 23; disp_sel=10 reads 8'h10.
- Assert hold for 5 cycles during ISSUE of field 3 -> rd_en stays low for those 5 cycles, frame_done at cycle 28, data correct.
- Pulse refresh_tick three times mid-frame -> exactly one extra frame, starting the cycle after COMMIT; no third frame.
- Change field 0 from 8'h59 to 8'h00 mid-frame after it has been captured -> disp_data for field 0 stays 8'h59 until frame_done. The next frame shows 8'h00.
- Drop reset at cycle 10 of a frame -> all outputs 0 immediately, no frame_done, and a new tick runs a clean frame.
- With BCD_CHECK_EN, field 2 = 8'h3A -> disp_data for field 2 = 8'h00 and bcd_err=1; the next tick clears bcd_err.
